// File: rtl/instr_enc_pkg.sv
// Shared encodings for the RV32I instruction encoder: request classes, AluOp codes, opcodes, FSM states.
// ENC_NOP_PAD_EN adds the PAD state used for NOP fill.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3
  } cls_e;

  // Same numbering as the single-cycle control decoder
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_e;

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_PAD} st_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE} st_e;
`endif

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB: alu_funct3 = 3'b000;
      ALU_SLL:          alu_funct3 = 3'b001;
      ALU_SLT:          alu_funct3 = 3'b010;
      ALU_SLTU:         alu_funct3 = 3'b011;
      ALU_XOR:          alu_funct3 = 3'b100;
      ALU_SRL, ALU_SRA: alu_funct3 = 3'b101;
      ALU_OR:           alu_funct3 = 3'b110;
      ALU_AND:          alu_funct3 = 3'b111;
      default:          alu_funct3 = 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] alu_funct7(input logic [3:0] op);
    alu_funct7 = (op == ALU_SUB || op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational field-to-word packing for R / I-ALU / LOAD / STORE plus the legality check.
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [3:0]  aluop,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic [11:0] imm_i;

  assign f3       = alu_funct3(aluop);
  assign f7       = alu_funct7(aluop);
  assign is_shift = (aluop == ALU_SLL) || (aluop == ALU_SRL) || (aluop == ALU_SRA);
  // Shift immediates carry funct7 in the upper bits; the caller's imm[11:5] is dropped
  assign imm_i    = is_shift ? {f7, imm[4:0]} : imm;

  always_comb begin
    word    = 32'h0;
    illegal = (cls > 3'd3) || (aluop > 4'd9);
    case (cls)
      CLS_R: word = {f7, rs2, rs1, f3, rd, OP_R};
      CLS_I: begin
        word = {imm_i, rs1, f3, rd, OP_I};
        if (aluop == ALU_SUB) illegal = 1'b1;
      end
      CLS_LOAD: begin
        word = {imm, rs1, funct3, rd, OP_LOAD};
        if (!(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) illegal = 1'b1;
      end
      CLS_STORE: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      default: word = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Assembles symbolic requests into RV32I words and writes them sequentially to instruction memory.
// Define ENC_NOP_PAD_EN to enable pad_req: fill all remaining words with NOP (ADDI x0,x0,0).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256  // must not exceed 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              clear,
  input  logic              pad_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  st_e             state;
  logic            mem_we_r;
  logic [31:0]     word;
  logic            illegal;
  logic            xfer;
  logic            pad_go;
  logic [ADDR_W:0] cnt_nxt;

  instr_word_pack u_pack (
    .cls     (in_class),
    .aluop   (in_aluop),
    .funct3  (in_funct3),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  // count doubles as the write pointer; it only advances while below DEPTH
  assign full    = (count == DEPTH_C);
  assign cnt_nxt = count + 1'b1;

`ifdef ENC_NOP_PAD_EN
  assign pad_go   = pad_req && (state == ST_IDLE) && !full && !clear;
  assign in_ready = rst_n && (state == ST_IDLE) && !full && !clear && !pad_req;
`else
  logic unused_pad;
  assign unused_pad = pad_req;
  assign pad_go     = 1'b0;
  assign in_ready   = rst_n && (state == ST_IDLE) && !full && !clear;
`endif

  assign xfer   = in_valid && in_ready;
  // clear kills the strobe in the same cycle so an in-flight write never lands
  assign mem_we = mem_we_r && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      err       <= 1'b0;
      mem_we_r  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      count    <= '0;
      err      <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pad_go) begin
`ifdef ENC_NOP_PAD_EN
            state     <= ST_PAD;
            mem_we_r  <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= NOP_WORD;
`endif
          end else if (xfer) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              mem_we_r  <= 1'b1;
              mem_addr  <= count[ADDR_W-1:0];
              mem_wdata <= word;
            end
          end
        end
        ST_WRITE: begin
          mem_we_r <= 1'b0;
          state    <= ST_IDLE;
          if (!full) count <= cnt_nxt;
        end
`ifdef ENC_NOP_PAD_EN
        ST_PAD: begin
          count <= cnt_nxt;
          if (cnt_nxt < DEPTH_C) begin
            mem_addr <= cnt_nxt[ADDR_W-1:0];
          end else begin
            mem_we_r <= 1'b0;
            state    <= ST_IDLE;
          end
        end
`endif
        default: begin
          mem_we_r <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded directed test for instr_encoder (DEPTH=4); pad checks follow ENC_NOP_PAD_EN.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [3:0]        in_aluop;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [11:0]       in_imm;
  logic              clear;
  logic              pad_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_aluop  (in_aluop),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .clear     (clear),
    .pad_req   (pad_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [ADDR_W-1:0] exp_ptr  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic issue(input logic [2:0] c, input logic [3:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm, input int budget, output bit taken);
    in_class = c; in_aluop = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < budget && !taken; i++) begin
      @(negedge clk);
      if (in_ready) taken = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic req(input string name, input logic [2:0] c, input logic [3:0] op,
                     input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [11:0] imm, input logic [31:0] exp_word);
    bit t;
    issue(c, op, f3, rd, rs1, rs2, imm, 8, t);
    chk({name, "_accept"}, 32'(t), 32'd1);
    sb.push_back({exp_ptr, exp_word});
    exp_ptr++;
  endtask

  task automatic bad(input string name, input logic [2:0] c, input logic [3:0] op,
                     input logic [2:0] f3);
    bit t;
    issue(c, op, f3, 5'd1, 5'd2, 5'd3, 12'h010, 8, t);
    chk({name, "_accept"}, 32'(t), 32'd1);
    tick(1);
    chk({name, "_err"}, 32'(err), 32'd1);
    chk({name, "_count"}, 32'(count), 32'(exp_ptr));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_ptr = '0;
  endtask

  initial begin
    bit t;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; pad_req = 1'b0;
    in_class = '0; in_aluop = '0; in_funct3 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(3);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    req("add", 3'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3);
    tick(1);
    chk("add_count", 32'(count), 32'd1);
    do_clear();
    chk("clr1_count", 32'(count), 32'd0);

    req("sub", 3'd0, 4'd1, 3'd0, 5'd5, 5'd6, 5'd7, 12'h000, 32'h407302B3);
    req("addi", 3'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 12'h005, 32'h00500093);
    tick(1);
    chk("two_count", 32'(count), 32'd2);
    do_clear();

    req("srai", 3'd1, 4'd7, 3'd0, 5'd4, 5'd4, 5'd0, 12'hFE3, 32'h40325213);
    req("lw", 3'd2, 4'd0, 3'd2, 5'd2, 5'd1, 5'd0, 12'h008, 32'h0080A103);
    req("sw", 3'd3, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 12'h00C, 32'h0020A623);
    tick(1);
    chk("three_count", 32'(count), 32'd3);
    bad("isub", 3'd1, 4'd1, 3'd0);
    do_clear();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_count", 32'(count), 32'd0);

    bad("cls5", 3'd5, 4'd0, 3'd0);
    do_clear();
    bad("alu12", 3'd0, 4'd12, 3'd0);
    do_clear();
    bad("ld_f3", 3'd2, 4'd0, 3'd3);
    do_clear();
    bad("st_f3", 3'd3, 4'd0, 3'd4);
    do_clear();

    req("xor", 3'd0, 4'd2, 3'd0, 5'd8, 5'd9, 5'd10, 12'h000, 32'h00A4C433);
    req("ori", 3'd1, 4'd4, 3'd0, 5'd1, 5'd2, 5'd0, 12'h7FF, 32'h7FF16093);
    req("slli", 3'd1, 4'd5, 3'd0, 5'd3, 5'd3, 5'd0, 12'hFFF, 32'h01F19193);
    req("sltu", 3'd0, 4'd9, 3'd0, 5'd31, 5'd30, 5'd29, 12'h000, 32'h01DF3FB3);
    tick(1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    issue(3'd0, 4'd3, 3'd0, 5'd1, 5'd1, 5'd1, 12'h000, 6, t);
    chk("full_stall", 32'(t), 32'd0);
    chk("full_err", 32'(err), 32'd0);
    chk("full_count2", 32'(count), 32'd4);

    do_clear();
    issue(3'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'h000, 8, t);
    chk("abort_accept", 32'(t), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("abort_count", 32'(count), 32'd0);
    tick(1);
    chk("abort_count2", 32'(count), 32'd0);

    req("pre_pad", 3'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3);
    tick(1);
    chk("pre_pad_count", 32'(count), 32'd1);
`ifdef ENC_NOP_PAD_EN
    for (int a = 1; a < DEPTH; a++) sb.push_back({ADDR_W'(a), 32'h00000013});
    pad_req = 1'b1;
    tick(1);
    pad_req = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      @(negedge clk);
      chk("pad_we", 32'(mem_we), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pad_done_we", 32'(mem_we), 32'd0);
    chk("pad_full", 32'(full), 32'd1);
    chk("pad_count", 32'(count), 32'(DEPTH));
    @(posedge clk); #1;
`else
    pad_req = 1'b1;
    tick(1);
    pad_req = 1'b0;
    tick(3);
    chk("nopad_count", 32'(count), 32'd1);
    chk("nopad_full", 32'(full), 32'd0);
`endif

    tick(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
